// File: rtl/data_mem_apb_bridge.sv
// data_mem_apb_bridge
// Bridges a CPU data-memory load/store port onto an APB master. Each CPU
// request becomes one APB transfer (SETUP then ACCESS), is completed with a
// single-cycle ready pulse, and stalls the CPU while the transfer is open.
// Misaligned requests complete immediately with err=1 and no APB activity.
// A transfer whose ACCESS phase sees PREADY low for TIMEOUT cycles is aborted
// with err=1.
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   req, we, addr,       CPU request (held stable while stall=1)
//   wdata, size
//   rdata, ready,        CPU response: LSB-aligned zero-extended load data,
//   stall, err           completion pulse, pipeline freeze, error flag
//   PADDR..PSTRB         APB master request outputs
//   PRDATA, PREADY,      APB completer response inputs
//   PSLVERR
//
// state  | meaning
// IDLE   | waiting for req; latches request fields
// SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS | APB access phase, waiting for PREADY or timeout
// RESP   | one-cycle ready pulse back to the CPU
module data_mem_apb_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT);

  state_t      state, state_next;
  logic [7:0]  tmo_cnt, tmo_cnt_next;
  logic [1:0]  addr_lo;
  logic [1:0]  size_q;
  logic        err_q;
  logic        latch;
  logic        misaligned;
  logic        xfer_done;
  logic        xfer_tmo;
  logic [3:0]  strb_req;
  logic [31:0] rdata_shift;
  logic [31:0] rdata_load;

  always_comb begin
    unique case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    unique case (size)
      2'b00:   strb_req = 4'b0001 << addr[1:0];
      2'b01:   strb_req = 4'b0011 << addr[1:0];
      default: strb_req = 4'b1111;
    endcase
  end

  // Load data is shifted down to bit 0 and zero-extended above the access size.
  assign rdata_shift = PRDATA >> {addr_lo, 3'b000};

  always_comb begin
    unique case (size_q)
      2'b00:   rdata_load = {24'h0, rdata_shift[7:0]};
      2'b01:   rdata_load = {16'h0, rdata_shift[15:0]};
      default: rdata_load = rdata_shift;
    endcase
  end

  always_comb begin
    state_next   = state;
    tmo_cnt_next = tmo_cnt;
    latch        = 1'b0;
    xfer_done    = 1'b0;
    xfer_tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          latch = 1'b1;
          if (misaligned) begin
            state_next = RESP;
          end else begin
            state_next   = SETUP;
            tmo_cnt_next = 8'd0;
          end
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          xfer_done  = 1'b1;
          state_next = RESP;
        end else begin
          tmo_cnt_next = tmo_cnt + 8'd1;
          if (({1'b0, tmo_cnt} + 9'd1) >= TMO_LIMIT) begin
            xfer_tmo   = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= 8'd0;
      PADDR   <= 32'h0;
      PWRITE  <= 1'b0;
      PWDATA  <= 32'h0;
      PSTRB   <= 4'b0000;
      addr_lo <= 2'b00;
      size_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      state   <= state_next;
      tmo_cnt <= tmo_cnt_next;
      if (latch) begin
        PADDR   <= {addr[31:2], 2'b00};
        PWRITE  <= we;
        PWDATA  <= wdata << {addr[1:0], 3'b000};
        PSTRB   <= we ? strb_req : 4'b0000;
        addr_lo <= addr[1:0];
        size_q  <= size;
        err_q   <= misaligned;
        if (misaligned && !we) rdata <= 32'h0;
      end
      if (xfer_done) begin
        err_q <= PSLVERR;
        if (!PWRITE) rdata <= PSLVERR ? 32'h0 : rdata_load;
      end
      if (xfer_tmo) begin
        err_q <= 1'b1;
        if (!PWRITE) rdata <= 32'h0;
      end
    end
  end

  assign PSEL    = (state == SETUP) || (state == ACCESS);
  assign PENABLE = (state == ACCESS);
  assign ready   = (state == RESP);
  assign err     = ready & err_q;
  assign stall   = !reset && (((state == IDLE) && req) || PSEL);

endmodule
